// File: rtl/lua_mem_pkg.sv
// rtl/lua_mem_pkg.sv - shared constants and address helper for the Lua VM state memory
package lua_mem_pkg;

  localparam logic [31:0] BAD_READ_DATA  = 32'hDEAD_BEEF;
  localparam int          WAIT_CNT_W     = 4;
  localparam int          CI_L_OFFSET    = 16;
  localparam int          SAVEDPC_OFFSET = 4;

  // Byte address to word index relative to the slave window; out-of-window
  // addresses (including below base, which wrap) come out large.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/lua_state_mem_slave_if.sv
// rtl/lua_state_mem_slave_if.sv - Avalon-MM bus between lua_cpu master and state memory slave
interface lua_state_mem_slave_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/lua_mem_array.sv
// rtl/lua_mem_array.sv - DEPTH x 32 register array, one sync write port, one async read port
module lua_mem_array #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately not reset; the preload port fills them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lua_state_mem_slave.sv
// rtl/lua_state_mem_slave.sv - Avalon-MM slave with programmable wait states and preload port
// Optional access counters enabled by defining LUA_MEM_STATS_EN.
module lua_state_mem_slave
  import lua_mem_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                     clock_sink_clk,
  input  logic                     reset_sink_reset,
  lua_state_mem_slave_if.slave     avalon_slave,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     err_pulse,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic          req, waitreq, done, bad;
  logic [31:0]   word_off;
  logic [AW-1:0] idx;
  logic [31:0]   arr_rdata, arr_wdata, rdata;
  logic [AW-1:0] arr_waddr;
  logic          arr_we;

  always_comb begin
    req      = avalon_slave.read | avalon_slave.write;
    word_off = word_index(avalon_slave.address, BASE_ADDR);
    idx      = word_off[AW-1:0];
    bad      = (avalon_slave.address[1:0] != 2'b00) || (word_off >= 32'(DEPTH)) ||
               (avalon_slave.read && avalon_slave.write);
    // Preload owns the write port for the cycle, so Avalon is stalled then.
    waitreq  = reset_sink_reset | load_en | (req && (cnt_q != WS));
    done     = req && !waitreq;
  end

  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!req || done) begin
      cnt_d = '0;
    end else if (waitreq && !load_en) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = done && bad;
  end

  always_comb begin
    rdata = '0;
    if (done && avalon_slave.read) begin
      rdata = bad ? BAD_READ_DATA : arr_rdata;
    end
    if (load_en) begin
      arr_we    = 1'b1;
      arr_waddr = load_addr;
      arr_wdata = load_data;
    end else begin
      arr_we    = done && avalon_slave.write && !bad;
      arr_waddr = idx;
      arr_wdata = avalon_slave.writedata;
    end
  end

  assign avalon_slave.readdata    = rdata;
  assign avalon_slave.waitrequest = waitreq;
  assign err_pulse                = err_q;

  lua_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clock_sink_clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (idx),
    .rdata (arr_rdata)
  );

`ifdef LUA_MEM_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q + {31'b0, done && avalon_slave.read};
    wr_count_d = wr_count_q + {31'b0, done && avalon_slave.write};
  end

  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_lua_state_mem_slave.sv
// tb/tb_lua_state_mem_slave.sv - scoreboard bench for lua_state_mem_slave
module tb_lua_state_mem_slave;

  localparam int DEPTH = 64;
  localparam int WS    = 1;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        err_pulse;
  logic [31:0] rd_count, wr_count;

  lua_state_mem_slave_if avs();

  lua_state_mem_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) dut (
    .clock_sink_clk   (clk),
    .reset_sink_reset (rst),
    .avalon_slave     (avs),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .err_pulse        (err_pulse),
    .rd_count         (rd_count),
    .wr_count         (wr_count)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  int   wcnt = 0;
  logic err_pend = 1'b0;
  logic err_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed Avalon access.
  always @(negedge clk) begin
    exp_t e;
    if (err_pend) begin
      chk("err_pulse", 32'(err_pulse), 32'(err_exp));
      err_pend = 1'b0;
    end
    if (rst) begin
      wcnt = 0;
    end else if (avs.read || avs.write) begin
      if (avs.waitrequest) begin
        if (!load_en) wcnt++;
      end else begin
        if (sb_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.is_rd) chk("readdata", avs.readdata, e.data);
          chk("wait_cycles", 32'(wcnt), 32'(WS));
          err_pend = 1'b1;
          err_exp  = e.err;
        end
        wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input logic err);
    exp_t e;
    e.is_rd = rd;
    e.data  = exp;
    e.err   = err;
    sb_q.push_back(e);
    avs.read      = rd;
    avs.write     = wr;
    avs.address   = addr;
    avs.writedata = wdata;
  endtask

  task automatic finish_access();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!avs.waitrequest) break;
    end
    if (k == 40) chk("access_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    avs.read  = 1'b0;
    avs.write = 1'b0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input logic err);
    issue(rd, wr, addr, wdata, exp, err);
    finish_access();
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  vec_t vecs_b[13];
  int   exp_rd, exp_wr;

  initial begin
    avs.read = 1'b0; avs.write = 1'b0; avs.address = '0; avs.writedata = '0;
    vecs_b = '{
      '{1'b0, 1'b1, 32'h50, 32'h2000_0020, 32'h0, 1'b0},
      '{1'b0, 1'b1, 32'h54, 32'h2000_0021, 32'h0, 1'b0},
      '{1'b0, 1'b1, 32'h58, 32'h2000_0022, 32'h0, 1'b0},
      '{1'b1, 1'b0, 32'h50, 32'h0, 32'h2000_0020, 1'b0},
      '{1'b1, 1'b0, 32'h54, 32'h0, 32'h2000_0021, 1'b0},
      '{1'b1, 1'b0, 32'h58, 32'h0, 32'h2000_0022, 1'b0},
      '{1'b1, 1'b0, 32'h14, 32'h0, 32'h0000_0044, 1'b0},
      '{1'b1, 1'b0, 32'h00, 32'h0, 32'hA0A0_0000, 1'b0},
      '{1'b1, 1'b0, 32'hFC, 32'h0, 32'h6363_6363, 1'b0},
      '{1'b1, 1'b0, 32'h1C, 32'h0, 32'h5555_AAAA, 1'b0},
      '{1'b1, 1'b0, 32'h44, 32'h0, 32'h1111_0017, 1'b0},
      '{1'b1, 1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF, 1'b1},
      '{1'b1, 1'b0, 32'h50, 32'h0, 32'h2000_0020, 1'b0}
    };

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", 32'(avs.waitrequest), 32'd1);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_wr_count", wr_count, 32'd0);
    chk("rst_readdata", avs.readdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_waitrequest", 32'(avs.waitrequest), 32'd0);
    @(posedge clk);
    #1;

    preload(6'd0, 32'hA0A0_0000);
    preload(6'd5, 32'h1234_5678);
    preload(6'd7, 32'h0000_7777);
    preload(6'd17, 32'h1111_0017);
    preload(6'd63, 32'h6363_6363);

    access(1'b1, 1'b0, 32'h14, 32'h0, 32'h1234_5678, 1'b0);
    access(1'b0, 1'b1, 32'h14, 32'hCAFE_0001, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h14, 32'h0, 32'hCAFE_0001, 1'b0);

    access(1'b0, 1'b1, 32'h14, 32'h40, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h14, 32'h0, 32'h40, 1'b0);
    access(1'b0, 1'b1, 32'h14, 32'h44, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h44, 32'h0, 32'h1111_0017, 1'b0);
    access(1'b1, 1'b0, 32'h14, 32'h0, 32'h44, 1'b0);

    access(1'b1, 1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF, 1'b1);
    access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1);
    access(1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h00, 32'h0, 32'hA0A0_0000, 1'b0);
    access(1'b1, 1'b0, 32'hFC, 32'h0, 32'h6363_6363, 1'b0);
    access(1'b1, 1'b1, 32'h00, 32'h99, 32'hDEAD_BEEF, 1'b1);
    access(1'b1, 1'b0, 32'h00, 32'h0, 32'hA0A0_0000, 1'b0);

    // Preload stalls a pending read for three cycles, then the new word is returned.
    issue(1'b1, 1'b0, 32'h1C, 32'h0, 32'h5555_AAAA, 1'b0);
    @(negedge clk);
    chk("t5_first_wait", 32'(avs.waitrequest), 32'd1);
    @(posedge clk);
    #1;
    load_en = 1'b1; load_addr = 6'd7; load_data = 32'h5555_AAAA;
    repeat (3) begin
      @(negedge clk);
      chk("t5_load_stall", 32'(avs.waitrequest), 32'd1);
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
    finish_access();

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    foreach (vecs_b[i]) begin
      access(vecs_b[i].rd, vecs_b[i].wr, vecs_b[i].addr, vecs_b[i].wdata,
             vecs_b[i].exp, vecs_b[i].err);
    end
`ifdef LUA_MEM_STATS_EN
    exp_rd = 10;
    exp_wr = 3;
`else
    exp_rd = 0;
    exp_wr = 0;
`endif
    @(negedge clk);
    chk("rd_count", rd_count, 32'(exp_rd));
    chk("wr_count", wr_count, 32'(exp_wr));

    // Reset lands while a write is still waiting: it must not commit.
    @(posedge clk);
    #1;
    avs.write = 1'b1; avs.address = 32'h50; avs.writedata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("t6_mid_wait", 32'(avs.waitrequest), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 avs.write = 1'b0;
    @(negedge clk);
    chk("t6_rst_waitrequest", 32'(avs.waitrequest), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rd_count_cleared", rd_count, 32'd0);
    chk("t6_wr_count_cleared", wr_count, 32'd0);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h50, 32'h0, 32'h2000_0020, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
